// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver that deframes scan codes into a small FIFO
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT);

    logic [2:0]            sc_q;
    logic [1:0]            sd_q;
    logic [3:0]            bit_q;
    logic [9:0]            sh_q;
    logic [TW-1:0]         to_q;
    logic                  push_q;
    logic                  err_q;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_q;
    logic [DEPTH_LOG2-1:0] rd_d;
    logic [DEPTH_LOG2-1:0] wr_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  ovf_q;
    logic [7:0]            data_q;
    logic                  fall;
    logic                  din;
    logic                  last;
    logic                  good;
    logic                  tmo;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

    assign data      = data_q;
    assign ready     = cnt_q != '0;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

    // Edge detect, frame check and FIFO bookkeeping decoded from current state
    always_comb begin
        fall  = sc_q[2] & ~sc_q[1];
        din   = sd_q[1];
        last  = bit_q == 4'd10;
        good  = ~sh_q[0] & din & (^sh_q[9:1]);
        tmo   = (bit_q != 4'd0) && (to_q == TW'(TIMEOUT - 1));
        full  = cnt_q[DEPTH_LOG2];
        pop   = ready && !nextdata_n;
        wr_en = push_q && (!full || pop);
        rd_d  = rd_q + DEPTH_LOG2'(pop);
        cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
    end

    // Bring the asynchronous PS/2 lines into the clk domain
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sc_q <= 3'b111;
            sd_q <= 2'b11;
        end else begin
            sc_q <= {sc_q[1:0], ps2_clk};
            sd_q <= {sd_q[0], ps2_data};
        end
    end

    // Shift in frame bits, judge the frame on its stop bit and abandon stalled frames
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_q  <= '0;
            sh_q   <= '0;
            to_q   <= '0;
            push_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            push_q <= fall && last && good;
            err_q  <= (fall && last && !good) || (!fall && tmo);
            if (fall) begin
                to_q  <= '0;
                bit_q <= last ? 4'd0 : bit_q + 4'd1;
                if (!last) sh_q <= {din, sh_q[9:1]};
            end else if (tmo) begin
                to_q  <= '0;
                bit_q <= '0;
            end else if (bit_q != 4'd0) begin
                to_q <= to_q + TW'(1);
            end
        end
    end

    // Storage array; the judged byte stays in the shift register until the next frame starts
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= sh_q[8:1];
    end

    // Pointers, occupancy, sticky overflow and a head register that forwards a write into an empty slot
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_q + DEPTH_LOG2'(wr_en);
            cnt_q <= cnt_d;
            if (push_q && full && !pop) ovf_q <= 1'b1;
            else if (pop) ovf_q <= 1'b0;
            if (cnt_d != '0) data_q <= (wr_en && wr_q == rd_d) ? sh_q[8:1] : mem[rd_d];
        end
    end
endmodule
